// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - command codes, FSM encoding and frame builder for the SPI command master
package spi_cmd_pkg;

    localparam int FRAME_BITS = 32;

    localparam logic [7:0] CMD_START    = 8'h01;
    localparam logic [7:0] CMD_STOP     = 8'h02;
    localparam logic [7:0] CMD_TON      = 8'h10;
    localparam logic [7:0] CMD_TOFF     = 8'h11;
    localparam logic [7:0] CMD_IP       = 8'h12;
    localparam logic [7:0] CMD_WAVEFORM = 8'h13;
    localparam logic [7:0] CMD_FEEDBACK = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Frame layout: cmd, payload, then the XOR check byte over cmd and both payload bytes.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] cmd,
                                                          input logic [15:0] data);
        return {cmd, data, cmd ^ data[15:8] ^ data[7:0]};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period divider with rise/fall strobes, held idle-low when disabled
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_term;

    // Strobes fire on the last cycle of a half-period, i.e. on the edge where sclk toggles.
    assign w_term = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise = w_term && !r_level;
    assign o_fall = w_term && r_level;
    assign o_sclk = r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_term) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_cmd.sv
// rtl/spi_master_cmd.sv - SPI mode-0 master sending one 32-bit command frame per request
module spi_master_cmd
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int FRAME_GAP = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_data,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);

    spi_state_t      r_state;
    spi_state_t      w_state_next;
    logic [7:0]      r_wait;
    logic [5:0]      r_bit_cnt;
    logic [31:0]     r_tx_sr;
    logic [31:0]     r_rx_sr;
    logic [31:0]     r_rx_data;
    logic            r_done;
    logic [1:0]      r_miso_sync;
    logic            w_accept;
    logic            w_wait_last;
    logic            w_sclk;
    logic            w_rise;
    logic            w_fall;
    logic            w_shift_en;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_shift_en = (r_state == ST_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_en   (w_shift_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_wait_last = 1'b0;
        case (r_state)
            ST_SETUP: w_wait_last = (r_wait == 8'(CS_SETUP - 1));
            ST_HOLD:  w_wait_last = (r_wait == 8'(CS_HOLD - 1));
            ST_GAP:   w_wait_last = (r_wait == 8'(FRAME_GAP - 1));
            default:  w_wait_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_SETUP;
            ST_SETUP: if (w_wait_last) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_fall && (r_bit_cnt == 6'(FRAME_BITS - 1))) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_wait_last) w_state_next = ST_GAP;
            ST_GAP:   if (w_wait_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wait      <= '0;
            r_bit_cnt   <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rx_data   <= '0;
            r_done      <= 1'b0;
            r_miso_sync <= '0;
        end else begin
            r_done      <= 1'b0;
            r_miso_sync <= {r_miso_sync[0], miso};

            if (r_state != w_state_next) begin
                r_wait <= '0;
            end else if ((r_state == ST_SETUP) || (r_state == ST_HOLD) || (r_state == ST_GAP)) begin
                r_wait <= r_wait + 8'd1;
            end

            // req_* is captured only here, so later changes cannot disturb the frame in flight.
            if (w_accept) begin
                r_tx_sr   <= build_frame(req_cmd, req_data);
                r_rx_sr   <= '0;
                r_bit_cnt <= '0;
            end

            if (w_shift_en && w_rise) begin
                r_rx_sr <= {r_rx_sr[30:0], r_miso_sync[1]};
            end

            if (w_shift_en && w_fall) begin
                r_tx_sr   <= {r_tx_sr[30:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if ((r_state == ST_HOLD) && w_wait_last) begin
                r_rx_data <= r_rx_sr;
                r_done    <= 1'b1;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign cs_n      = !((r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD));
    assign mosi      = ((r_state == ST_SETUP) || (r_state == ST_SHIFT)) ? r_tx_sr[31] : 1'b0;
    assign sclk      = w_sclk;
    assign done      = r_done;
    assign rx_data   = r_rx_data;

endmodule

// File: tb/tb_spi_master_cmd.sv
// tb/tb_spi_master_cmd.sv - scoreboard bench for spi_master_cmd with an SPI slave model
module tb_spi_master_cmd;
    import spi_cmd_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int CS_SETUP  = 2;
    localparam int CS_HOLD   = 2;
    localparam int FRAME_GAP = 4;
    localparam int ACC_TO_RISE = 1 + CS_SETUP + 64 * CLK_DIV + CS_HOLD;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [15:0] req_data = 16'h0000;
    logic        done;
    logic [31:0] rx_data;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        miso = 1'b0;

    spi_master_cmd #(
        .CLK_DIV   (CLK_DIV),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .done      (done),
        .rx_data   (rx_data),
        .busy      (busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .miso      (miso)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   dones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave: shifts mosi in on sclk rise, presents miso MSB first, updating on sclk fall.
    logic [31:0] slv_word = 32'h0;
    logic [31:0] slv_rx = 32'h0;
    int          slv_idx = 32;

    always @(negedge cs_n or posedge sclk) begin
        if (sclk) slv_rx <= {slv_rx[30:0], mosi};
        else      slv_rx <= 32'h0;
    end

    always @(cs_n or negedge sclk) begin
        if (cs_n)               slv_idx = 32;
        else if (slv_idx == 32) slv_idx = 31;
        else if (slv_idx > 0)   slv_idx = slv_idx - 1;
        miso = (cs_n || slv_idx > 31) ? 1'b0 : slv_word[slv_idx];
    end

    // Monitor: per-frame timing trackers, scoreboard pop on every done pulse.
    int   mon_age = -1;
    int   mon_rises = 0;
    int   mon_rise_at = 0;
    int   mon_high = 0;
    bit   mon_fall_chk = 0;
    bit   mon_prev_sclk = 0;
    bit   mon_prev_cs = 1;
    bit   mon_had_frame = 0;
    bit   mon_glitch = 0;
    bit   mon_rdy_bad = 0;
    exp_t e;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            mon_age = -1;
            mon_rises = 0;
            mon_high = 0;
            mon_fall_chk = 0;
            mon_prev_sclk = 0;
            mon_prev_cs = 1;
        end else begin
            if (mon_fall_chk) begin
                chk("cs_fall_after_accept", {31'd0, cs_n}, 32'd0);
                mon_fall_chk = 0;
            end
            if (mon_age >= 0) mon_age++;
            if (sclk && !mon_prev_sclk) mon_rises++;
            if (cs_n && sclk) mon_glitch = 1;
            if (busy && req_ready) mon_rdy_bad = 1;
            if (!cs_n && mon_prev_cs && mon_had_frame)
                chk("gap_at_least_frame_gap", {31'd0, mon_high >= FRAME_GAP}, 32'd1);
            if (cs_n && !mon_prev_cs) mon_rise_at = mon_age;
            mon_high = cs_n ? mon_high + 1 : 0;
            if (done) begin
                dones++;
                mon_had_frame = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mosi_frame", slv_rx, e.frame);
                    chk("rx_data", rx_data, e.rx);
                    chk("sclk_rises", mon_rises, 32);
                    chk("accept_to_cs_rise", mon_rise_at, ACC_TO_RISE);
                    chk("ready_low_while_busy", {31'd0, mon_rdy_bad}, 32'd0);
                    chk("sclk_low_while_cs_high", {31'd0, mon_glitch}, 32'd0);
                end
            end
            if (req_valid && req_ready) begin
                accepts++;
                mon_age = 0;
                mon_rises = 0;
                mon_fall_chk = 1;
            end
            mon_prev_cs = cs_n;
            mon_prev_sclk = sclk;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_accept(input int target);
        int budget = 2000;
        while (accepts < target && budget > 0) begin
            tick();
            budget--;
        end
        if (accepts < target) chk("accept_timeout", accepts, target);
    endtask

    task automatic wait_dones(input int target);
        int budget = 2000;
        while (dones < target && budget > 0) begin
            tick();
            budget--;
        end
        if (dones < target) chk("done_timeout", dones, target);
    endtask

    task automatic issue(input logic [7:0] cmd, input logic [15:0] data);
        req_cmd = cmd;
        req_data = data;
        req_valid = 1'b1;
        wait_accept(accepts + 1);
        req_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] frame, input logic [31:0] rx);
        exp_t x;
        x.frame = frame;
        x.rx = rx;
        exp_q.push_back(x);
    endtask

    int base;

    initial begin
        repeat (3) tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);

        // 1: CMD_TON 0x01F4
        slv_word = 32'hA5C3_3CA5;
        push(32'h1001_F4E5, 32'hA5C3_3CA5);
        issue(CMD_TON, 16'h01F4);
        wait_dones(1);

        // 2: feedback word, single done pulse
        repeat (10) tick();
        slv_word = 32'h0F0F_0F0F;
        push(32'h2000_0020, 32'h0F0F_0F0F);
        base = dones;
        issue(CMD_FEEDBACK, 16'h0000);
        wait_dones(base + 1);
        repeat (300) tick();
        chk("single_done_pulse", dones, base + 1);

        // 3 and 6: valid held for three back-to-back frames
        slv_word = 32'h1234_8765;
        push(32'h0101_0202, 32'h1234_8765);
        push(32'h1100_C8D9, 32'h1234_8765);
        push(32'h135A_5A13, 32'h1234_8765);
        base = dones;
        req_cmd = CMD_START;    req_data = 16'h0102; req_valid = 1'b1;
        wait_accept(accepts + 1);
        req_cmd = CMD_TOFF;     req_data = 16'h00C8;
        wait_accept(accepts + 1);
        req_cmd = CMD_WAVEFORM; req_data = 16'h5A5A;
        wait_accept(accepts + 1);
        req_valid = 1'b0;
        wait_dones(base + 3);
        repeat (300) tick();
        chk("three_frames", dones, base + 3);

        // 4: req_data changes mid-frame
        slv_word = 32'hDEAD_BEEF;
        push(32'h1200_0311, 32'hDEAD_BEEF);
        base = dones;
        issue(CMD_IP, 16'h0003);
        repeat (9) tick();
        req_data = 16'hFFFF;
        wait_dones(base + 1);
        repeat (10) tick();

        // 5: reset at bit 15, then a full frame
        slv_word = 32'hCAFE_F00D;
        base = dones;
        issue(CMD_START, 16'h1234);
        begin
            int budget = 1000;
            while (mon_rises < 16 && budget > 0) begin
                tick();
                budget--;
            end
            chk("reach_bit15", {31'd0, mon_rises >= 16}, 32'd1);
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk}, 32'd0);
        chk("midrst_mosi", {31'd0, mosi}, 32'd0);
        chk("midrst_rx_data", rx_data, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (300) tick();
        chk("no_done_after_rst", dones, base);
        push(32'h02AB_CD64, 32'hCAFE_F00D);
        issue(CMD_STOP, 16'hABCD);
        wait_dones(base + 1);
        repeat (10) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
